// File: rtl/if_fetch_stage_pkg.sv
// Shared CPU constants and types used by the instruction-fetch stage.
// Holds widths, the NOP encoding, the fetch FSM states and the queue entry layout.
package if_fetch_stage_pkg;

  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;

  // addi x0, x0, 0
  localparam logic [DATA_BITS-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] pc;
    logic [DATA_BITS-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_BITS-1:0] next_pc(input logic [ADDR_BITS-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage (master) and the memory wrapper (slave).
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic                 im_req_o;
  logic [ADDR_BITS-1:0] im_addr_o;
  logic                 im_rvalid_i;
  logic [DATA_BITS-1:0] im_rdata_i;

  modport master (output im_req_o, output im_addr_o, input im_rvalid_i, input im_rdata_i);
  modport slave  (input im_req_o, input im_addr_o, output im_rvalid_i, output im_rdata_i);
endinterface

// File: rtl/if_fetch_queue.sv
// Two-entry FIFO of fetched {pc, inst} pairs between the memory response and IF/ID.
// Push when full and pop when empty are ignored; clear empties it in one cycle.
module if_fetch_queue
  import if_fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem_r [2];
  logic         wr_ptr_r;
  logic         rd_ptr_r;
  logic [1:0]   count_r;
  logic         push_ok_s;
  logic         pop_ok_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer, count and storage update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else if (clear) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: single-outstanding memory requests, 2-entry fetch queue, IF/ID register.
// Redirects retarget fetch, clear the queue and let an in-flight response drain as a discard.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] RESET_PC = 32'h0000_0000,
  parameter int                   Q_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  if_fetch_stage_if.master     im,
  input  logic                 redirect_i,
  input  logic [ADDR_BITS-1:0] redirect_pc_i,
  input  logic                 ifid_en_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  output logic [ADDR_BITS-1:0] pc_o,
  output logic [DATA_BITS-1:0] inst_o
);

  fetch_state_e         state_r;
  logic                 req_r;
  logic [ADDR_BITS-1:0] addr_r;
  logic [ADDR_BITS-1:0] fetch_pc_r;
  logic [ADDR_BITS-1:0] ifid_pc_r;
  logic [DATA_BITS-1:0] ifid_inst_r;
  logic                 push_s;
  logic                 pop_s;
  logic                 room_s;
  logic [2:0]           next_count_s;
  logic                 q_full_s;
  logic                 q_empty_s;
  logic [1:0]           q_count_s;
  fetch_entry_t         q_head_s;
  fetch_entry_t         q_wr_s;

  assign im.im_req_o  = req_r;
  assign im.im_addr_o = addr_r;
  assign pc_o         = ifid_pc_r;
  assign inst_o       = ifid_inst_r;

  assign q_wr_s = '{pc: addr_r, inst: im.im_rdata_i};

  // Queue traffic and the room rule: occupancy after this cycle's push and pop
  always_comb begin
    push_s       = (state_r == FETCH_WAIT) & im.im_rvalid_i & ~redirect_i;
    pop_s        = ifid_en_i & ~stall_i & ~flush_i & ~redirect_i & ~q_empty_s;
    next_count_s = {1'b0, q_count_s} + {2'b00, push_s} - {2'b00, pop_s};
    room_s       = (next_count_s < 3'(Q_DEPTH));
  end

  if_fetch_queue u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .pop      (pop_s),
    .clear    (redirect_i),
    .wr_entry (q_wr_s),
    .head     (q_head_s),
    .full     (q_full_s),
    .empty    (q_empty_s),
    .count    (q_count_s)
  );

  // Fetch FSM; in DROP the request is held until the memory completes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= FETCH_IDLE;
      req_r      <= 1'b0;
      addr_r     <= RESET_PC;
      fetch_pc_r <= RESET_PC;
    end else begin
      case (state_r)
        FETCH_IDLE: begin
          if (redirect_i) begin
            fetch_pc_r <= redirect_pc_i;
          end else if (room_s) begin
            state_r <= FETCH_WAIT;
            req_r   <= 1'b1;
            addr_r  <= fetch_pc_r;
          end
        end
        FETCH_WAIT: begin
          if (redirect_i) begin
            fetch_pc_r <= redirect_pc_i;
            if (im.im_rvalid_i) begin
              state_r <= FETCH_IDLE;
              req_r   <= 1'b0;
            end else begin
              state_r <= FETCH_DROP;
            end
          end else if (im.im_rvalid_i) begin
            fetch_pc_r <= next_pc(addr_r);
            if (room_s) begin
              addr_r <= next_pc(addr_r);
            end else begin
              state_r <= FETCH_IDLE;
              req_r   <= 1'b0;
            end
          end
        end
        FETCH_DROP: begin
          if (redirect_i) begin
            fetch_pc_r <= redirect_pc_i;
          end
          if (im.im_rvalid_i) begin
            state_r <= FETCH_IDLE;
            req_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= FETCH_IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush or redirect squash to NOP, empty queue inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_pc_r   <= 32'h0000_0000;
      ifid_inst_r <= NOP_INST;
    end else if (ifid_en_i) begin
      if (flush_i | redirect_i) begin
        ifid_inst_r <= NOP_INST;
      end else if (!stall_i) begin
        if (!q_empty_s) begin
          ifid_pc_r   <= q_head_s.pc;
          ifid_inst_r <= q_head_s.inst;
        end else begin
          ifid_inst_r <= NOP_INST;
        end
      end
    end
  end

endmodule
